// File: rtl/remote_frame_decoder.sv
// -----------------------------------------------------------------------------
// remote_frame_decoder
//
// Receives the raw remote-control line, synchronises and glitch-filters it,
// measures the interval between filtered edges and rebuilds the half-bit
// symbol stream of a biphase-mark (FM0) frame. A frame is
// {payload, reserved, parity}, sent MSB first, with odd overall parity. An
// accepted frame updates the payload, pulses o_valid and raises o_active.
// After a long quiet period the momentary-button bits (CLEAR_MASK) are
// dropped and o_active falls. The other payload bits keep their value.
//
// Ports
//   i_clk          system clock
//   i_reset        synchronous, active-high reset
//   i_input        asynchronous remote line
//   o_payload      last accepted payload (PAYLOAD_W bits)
//   o_valid        one-cycle strobe per accepted frame
//   o_active       high from an accepted frame until the inactivity timeout
//   o_error_count  rejected-frame count, saturating at 255
//
// Optional feature: define REMOTE_ERROR_COUNT_EN to build the rejected-frame
// counter. Without it, o_error_count is tied to 0.
// -----------------------------------------------------------------------------
module remote_frame_decoder #(
    parameter int                   COUNT_W    = 16,
    parameter int                   PAYLOAD_W  = 12,
    parameter int                   RESERVED_W = 3,
    parameter int                   TIMEOUT_W  = 25,
    parameter int                   FILTER_LEN = 4,
    parameter logic [PAYLOAD_W-1:0] CLEAR_MASK = 12'hF00
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_input,
    output logic [PAYLOAD_W-1:0] o_payload,
    output logic                 o_valid,
    output logic                 o_active,
    output logic [7:0]           o_error_count
);

    localparam int FRAME_W  = PAYLOAD_W + RESERVED_W + 1;
    localparam int STREAM_W = 2 * FRAME_W + 4;

    // Count values at or above this mark a long (two half-bit) interval.
    localparam logic [COUNT_W-1:0]   CNT_LONG = {1'b1, {(COUNT_W-1){1'b0}}};
    // One below all-ones: the next increment saturates the timeout.
    localparam logic [TIMEOUT_W-1:0] TMO_PRE  = {{(TIMEOUT_W-1){1'b1}}, 1'b0};
    localparam logic [3:0]           FLT_LAST = 4'(FILTER_LEN - 1);

    // ---------------------------------------------------------------- input path
    logic [1:0]  r_sync;
    logic        r_level;
    logic        r_level_q;
    logic [3:0]  r_flt_cnt;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_sync    <= '0;
            r_level   <= 1'b0;
            r_level_q <= 1'b0;
            r_flt_cnt <= '0;
        end else begin
            r_sync    <= {r_sync[0], i_input};
            r_level_q <= r_level;
            // Level follows only after FILTER_LEN disagreeing samples in a row;
            // a single agreeing sample restarts the run.
            if (r_sync[1] != r_level) begin
                if (r_flt_cnt == FLT_LAST) begin
                    r_level   <= r_sync[1];
                    r_flt_cnt <= '0;
                end else begin
                    r_flt_cnt <= r_flt_cnt + 4'd1;
                end
            end else begin
                r_flt_cnt <= '0;
            end
        end
    end

    logic w_edge;
    logic w_old;
    assign w_edge = r_level ^ r_level_q;
    assign w_old  = r_level_q;

    // ------------------------------------------------------- interval / stream
    logic [COUNT_W-1:0]  r_count;
    logic [STREAM_W-1:0] r_stream;
    logic                r_shifted;
    logic                w_sat;
    logic                w_long;

    assign w_sat  = (r_count == '1);
    assign w_long = (r_count >= CNT_LONG);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_count   <= '0;
            r_stream  <= '0;
            r_shifted <= 1'b0;
        end else begin
            r_shifted <= w_edge && !w_sat;
            if (w_edge) begin
                r_count <= '0;
                if (w_sat)
                    r_stream <= '0;                            // sync gap
                else if (w_long)
                    r_stream <= {r_stream[STREAM_W-3:0], w_old, w_old};
                else
                    r_stream <= {r_stream[STREAM_W-2:0], w_old};
            end else if (!w_sat) begin
                r_count <= r_count + COUNT_W'(1);
            end
        end
    end

    // ------------------------------------------------------------ frame check
    logic [FRAME_W-1:0] w_decoded;
    logic [FRAME_W-1:0] w_bounds;
    logic               w_accept;

    // Decoded bit = the two half-bit symbols differ (mid-bit transition).
    // Boundary bit = a transition between this bit and the older neighbour.
    always_comb begin
        w_decoded = '0;
        w_bounds  = '0;
        for (int j = 0; j < FRAME_W; j++) begin
            w_decoded[j] = r_stream[2*j]   ^ r_stream[2*j+1];
            w_bounds[j]  = r_stream[2*j+1] ^ r_stream[2*j+2];
        end
    end

    assign w_accept = r_shifted
                   && (r_stream[STREAM_W-1 -: 4] == 4'd0)
                   && (&w_bounds)
                   && (w_decoded[RESERVED_W:1] == '0)
                   && (^w_decoded);

    // --------------------------------------------------- timeout and outputs
    logic [TIMEOUT_W-1:0] r_tmo;
    logic                 w_tmo_hit;

    // A Level edge in the saturating cycle wins: no clear happens.
    assign w_tmo_hit = !w_edge && (r_tmo == TMO_PRE);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_tmo     <= '0;
            o_payload <= '0;
            o_valid   <= 1'b0;
            o_active  <= 1'b0;
        end else begin
            if (w_edge)
                r_tmo <= '0;
            else if (r_tmo != '1)
                r_tmo <= r_tmo + TIMEOUT_W'(1);

            o_valid <= w_accept;
            if (w_accept) begin
                o_payload <= w_decoded[FRAME_W-1 -: PAYLOAD_W];
                o_active  <= 1'b1;
            end else if (w_tmo_hit) begin
                o_payload <= o_payload & ~CLEAR_MASK;
                o_active  <= 1'b0;
            end
        end
    end

    // ----------------------------------------------------- rejected frames
`ifdef REMOTE_ERROR_COUNT_EN
    logic       r_frame_seen;
    logic [7:0] r_err;

    // A sync gap that throws away a non-empty stream without an accepted
    // frame since the previous gap counts as one rejected frame.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_frame_seen <= 1'b0;
            r_err        <= '0;
        end else if (w_edge && w_sat) begin
            if ((r_stream != '0) && !r_frame_seen && (r_err != 8'hFF))
                r_err <= r_err + 8'd1;
            r_frame_seen <= 1'b0;
        end else if (w_accept) begin
            r_frame_seen <= 1'b1;
        end
    end

    assign o_error_count = r_err;
`else
    assign o_error_count = 8'h00;
`endif

endmodule
